// File: rtl/scope_pkg.sv
// Shared constants and state encoding for the oscilloscope front-end.
package scope_pkg;

    localparam int ADC_WIDTH      = 12;
    localparam int SPI_FRAME_BITS = 16;
    localparam int BIT_CNT_W      = $clog2(SPI_FRAME_BITS + 1);
    localparam int AVG_SUM_W      = ADC_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } adc_state_t;

    // Divide a four-sample sum by four, keeping the integer part.
    function automatic logic [ADC_WIDTH-1:0] avg4(input logic [AVG_SUM_W-1:0] sum);
        return sum[AVG_SUM_W-1:2];
    endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// SPI pin bundle between the sampler (master) and the serial ADC (slave).
interface adc_spi_if;
    logic sclk;
    logic cs_n;
    logic miso;

    modport master (output sclk, output cs_n, input miso);
    modport slave  (input sclk, input cs_n, output miso);
endinterface

// File: rtl/adc_spi_sampler_clk_div.sv
// SCLK generator: divider counter with idle-high serial clock and edge strobes.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q;
    logic          sclk_q;
    logic          term;

    assign term         = en_i && (div_q == DW'(CLK_DIV - 1));
    assign rise_pulse_o = term && !sclk_q;
    assign fall_pulse_o = term && sclk_q;
    assign sclk_o       = sclk_q;

    // Disabled means cleared: every frame starts with a full half-period high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else if (!en_i) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else if (term) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic 16-clock SPI read of a 12-bit serial ADC with a one-cycle result strobe.
// Define ADC_AVG4_EN to output a 4-sample moving average instead of the raw sample.
module adc_spi_sampler
    import scope_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_spi_if.master            spi,
    output logic [ADC_WIDTH-1:0] ADC_data,
    output logic                 sample_valid,
    output logic                 overrun
);
    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    adc_state_t            state_q;
    logic [TW-1:0]         tmr_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [ADC_WIDTH-1:0]  shift_q;
    logic [ADC_WIDTH-1:0]  data_q;
    logic                  cs_n_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  tick;
    logic                  frame_end;
    logic                  rise_pulse;
    logic                  fall_pulse;
    logic [ADC_WIDTH-1:0]  result;

    assign tick      = (tmr_q == TW'(SAMPLE_PERIOD - 1));
    assign frame_end = (state_q == CONV) && (bit_cnt_q == BIT_CNT_W'(SPI_FRAME_BITS));

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (state_q == CONV),
        .sclk_o       (spi.sclk),
        .rise_pulse_o (rise_pulse),
        .fall_pulse_o (fall_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr_q <= '0;
        else        tmr_q <= tick ? '0 : tmr_q + TW'(1);
    end

`ifdef ADC_AVG4_EN
    logic [ADC_WIDTH-1:0] hist_q [4];
    logic [AVG_SUM_W-1:0] sum_q;

    // History and sum update as the frame closes so the average is ready in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) hist_q[k] <= '0;
            sum_q <= '0;
        end else if (frame_end) begin
            hist_q[0] <= shift_q;
            for (int k = 1; k < 4; k++) hist_q[k] <= hist_q[k-1];
            sum_q <= AVG_SUM_W'(shift_q) + AVG_SUM_W'(hist_q[0])
                   + AVG_SUM_W'(hist_q[1]) + AVG_SUM_W'(hist_q[2]);
        end
    end

    assign result = avg4(sum_q);
`else
    assign result = shift_q;
`endif

    // The 12-bit shifter lets the four leading frame bits fall off the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tick && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q   <= CONV;
                        cs_n_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                CONV: begin
                    if (frame_end) begin
                        cs_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (rise_pulse) begin
                        shift_q   <= {shift_q[ADC_WIDTH-2:0], spi.miso};
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                DONE: begin
                    data_q  <= result;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi.cs_n     = cs_n_q;
    assign ADC_data     = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

    logic unused_fall;
    assign unused_fall = fall_pulse;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Two sampler instances: A (CLK_DIV=2, legal period, mid-frame reset) and B (defaults-style divider, overrunning period).
module tb_adc_spi_sampler;

    localparam int DA = 2;
    localparam int PA = 200;
    localparam int DB = 4;
    localparam int PB = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [11:0] data_a, data_b;
    logic        val_a, val_b, ovr_a, ovr_b;

    adc_spi_if if_a();
    adc_spi_if if_b();

    adc_spi_sampler #(.CLK_DIV(DA), .SAMPLE_PERIOD(PA)) u_a (
        .clk(clk), .rst_n(rst_a), .spi(if_a),
        .ADC_data(data_a), .sample_valid(val_a), .overrun(ovr_a)
    );

    adc_spi_sampler #(.CLK_DIV(DB), .SAMPLE_PERIOD(PB)) u_b (
        .clk(clk), .rst_n(rst_b), .spi(if_b),
        .ADC_data(data_b), .sample_valid(val_b), .overrun(ovr_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", name, act, $time);
        end
    endtask

    // Scoreboard: raw ADC values pushed when a frame starts, popped on sample_valid.
    logic [15:0] dir_a[$];
    logic [15:0] dir_b[$];
    logic [11:0] exp_a[$];
    logic [11:0] exp_b[$];
    logic [11:0] hist_a[$];
    logic [11:0] hist_b[$];

    bit          pcs[2], psclk[2], in_frame[2];
    int          rises[2], cyc[2], nvalid[2], last_csfall[2], bidx[2];
    logic [15:0] word[2];
    logic [11:0] last_out[2];
    int          tcnt = 0;

    // Reference output: raw value, or mean of the newest four raw values (missing ones count as 0).
    task automatic model_out(input int i, input logic [11:0] raw, output logic [11:0] res);
`ifdef ADC_AVG4_EN
        int sum;
        sum = 0;
        if (i == 0) begin
            hist_a.push_front(raw);
            if (hist_a.size() > 4) void'(hist_a.pop_back());
            foreach (hist_a[k]) sum += hist_a[k];
        end else begin
            hist_b.push_front(raw);
            if (hist_b.size() > 4) void'(hist_b.pop_back());
            foreach (hist_b[k]) sum += hist_b[k];
        end
        res = 12'(sum / 4);
`else
        res = raw;
`endif
    endtask

    task automatic drive_miso(input int i, input logic b);
        if (i == 0) if_a.miso = b;
        else        if_b.miso = b;
    endtask

    task automatic mon(input int i, input int d, input logic rstn, input logic cs,
                       input logic sc, input logic val, input logic [11:0] data);
        logic [11:0] raw, e;
        if (!rstn) begin
            if (in_frame[i]) begin
                if (i == 0) void'(exp_a.pop_back());
                else        void'(exp_b.pop_back());
            end
            in_frame[i] = 0; pcs[i] = 1; psclk[i] = 1;
            last_out[i] = '0; last_csfall[i] = -1;
            if (i == 0) hist_a.delete(); else hist_b.delete();
            drive_miso(i, 1'b0);
            return;
        end
        cyc[i]++;
        if (pcs[i] && !cs) begin
            chk("hold_between_strobes", data, last_out[i]);
            if (i == 1 && last_csfall[1] >= 0) chk("b_frame_spacing", tcnt - last_csfall[1], 2 * PB);
            last_csfall[i] = tcnt;
            if (i == 0 && dir_a.size() > 0)      word[i] = dir_a.pop_front();
            else if (i == 1 && dir_b.size() > 0) word[i] = dir_b.pop_front();
            else word[i] = {4'($urandom_range(0, 15)), 12'($urandom)};
            if (i == 0) exp_a.push_back(word[i][11:0]);
            else        exp_b.push_back(word[i][11:0]);
            in_frame[i] = 1; rises[i] = 0; cyc[i] = 0; bidx[i] = 15;
            drive_miso(i, word[i][15]);
        end else if (!cs && in_frame[i]) begin
            if (psclk[i] && !sc) begin
                if (rises[i] == 0) chk("first_sclk_fall", cyc[i], d);
                drive_miso(i, word[i][bidx[i]]);
                if (bidx[i] > 0) bidx[i]--;
            end
            if (!psclk[i] && sc) begin
                rises[i]++;
                chk("sclk_rise_time", cyc[i], 2 * d * rises[i]);
            end
        end
        if (!pcs[i] && cs && in_frame[i]) begin
            chk("rises_per_frame", rises[i], 16);
            chk("cs_n_rise_time", cyc[i], 32 * d + 1);
        end
        if (val) begin
            chk("valid_inside_frame", in_frame[i], 1);
            if (in_frame[i]) begin
                chk("valid_latency", cyc[i], 32 * d + 2);
                if (i == 0) raw = exp_a.pop_front();
                else        raw = exp_b.pop_front();
                model_out(i, raw, e);
                chk(i == 0 ? "a_adc_data" : "b_adc_data", data, e);
                last_out[i] = e;
                in_frame[i] = 0;
                nvalid[i]++;
            end
        end
        pcs[i] = cs;
        psclk[i] = sc;
    endtask

    always @(negedge clk) begin
        tcnt++;
        mon(0, DA, rst_a, if_a.cs_n, if_a.sclk, val_a, data_a);
        mon(1, DB, rst_b, if_b.cs_n, if_b.sclk, val_b, data_b);
    end

    task automatic clocks_to_cs_fall_a(output int n);
        n = 0;
        for (int k = 0; k < PA + 50; k++) begin
            @(posedge clk); #1;
            n++;
            if (!if_a.cs_n) break;
        end
    endtask

    initial begin
        int n, target;
        dir_a.push_back(16'h0123);
        dir_b.push_back(16'h0ABC);
        dir_b.push_back(16'h0FFF);
        dir_b.push_back(16'h0000);
        dir_b.push_back(16'hF555);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_cs_n", if_a.cs_n, 1);
        chk("rst_a_sclk", if_a.sclk, 1);
        chk("rst_a_data", data_a, 0);
        chk("rst_a_valid", val_a, 0);
        chk("rst_b_cs_n", if_b.cs_n, 1);
        chk("rst_b_overrun", ovr_b, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        clocks_to_cs_fall_a(n);
        chk("a_first_frame_delay", n, PA);

        for (int k = 0; k < 5000 && nvalid[0] < 3; k++) begin @(negedge clk); #1; end
        chk("a_frames_before_reset", nvalid[0] >= 3, 1);

        for (int k = 0; k < 5000 && !(in_frame[0] && rises[0] == 7 && !if_a.cs_n); k++) begin
            @(negedge clk); #1;
        end
        chk("a_reached_7_rises", rises[0], 7);
        rst_a = 1'b0;
        #1;
        chk("midrst_cs_n", if_a.cs_n, 1);
        chk("midrst_sclk", if_a.sclk, 1);
        chk("midrst_data", data_a, 0);
        chk("midrst_valid", val_a, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_no_valid", val_a, 0);
        rst_a = 1'b1;
        clocks_to_cs_fall_a(n);
        chk("a_frame_after_reset", n, PA);

        target = nvalid[0] + 3;
        for (int k = 0; k < 5000 && nvalid[0] < target; k++) begin @(negedge clk); #1; end
        chk("a_frames_after_reset", nvalid[0] >= target, 1);

        for (int k = 0; k < 5000 && nvalid[1] < 8; k++) begin @(negedge clk); #1; end
        chk("b_frames_done", nvalid[1] >= 8, 1);
        chk("b_overrun_set", ovr_b, 1);
        chk("a_no_overrun", ovr_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Front-end stage of the oscilloscope datapath. Periodically runs a 16-clock SPI read frame on an external 12-bit serial ADC (ADCS7476-style: 4 leading zeros, then 12 data bits, MSB first). Presents each conversion result as a registered 12-bit word with a one-cycle valid strobe. `ADC_data` feeds the voltage-to-digit calculator stage directly.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; legal range 2..255.
- `SAMPLE_PERIOD`, default 1000: system clocks between frame-start ticks; must be at least 32*`CLK_DIV`+4.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `miso` input, 1 bit: ADC serial data.
- `cs_n` output, 1 bit: ADC chip select, active-low. Reset value 1.
- `sclk` output, 1 bit: ADC serial clock; idles high. Reset value 1.
- `ADC_data` output, 12 bits: last completed conversion. Reset value 0.
- `sample_valid` output, 1 bit: high for exactly one clock when `ADC_data` updates. Reset value 0.
- `overrun` output, 1 bit: sticky flag, set when a tick is dropped. Reset value 0.

## Operation
- Tick timer counts 0..`SAMPLE_PERIOD`-1 and wraps. A tick is asserted on the cycle the count equals `SAMPLE_PERIOD`-1. The timer runs in every state.
- States: IDLE, CONV, DONE.
- IDLE: `cs_n`=1, `sclk`=1. On a tick, go to CONV: drive `cs_n`=0, clear the divider, bit counter and shift register.
- CONV: the divider counts 0..`CLK_DIV`-1; at terminal count `sclk` toggles.
  - On each low-to-high toggle, `miso` is shifted into a 16-bit shift register from the LSB side. The sample is the `miso` value in the same clock as the toggle.
  - Bit counter increments per rising edge, 0..15.
  - After the 16th rising edge: `cs_n`=1, go to DONE.
- DONE (one clock): `ADC_data` <= shift[11:0]; `sample_valid`=1; go to IDLE. Bits shift[15:12] are ignored.
- A tick that arrives in CONV or DONE is dropped and sets `overrun`. Only reset clears `overrun`.
- `miso` is treated as source-synchronous to the slow SCLK and is not synchronised.
- Asserting reset mid-frame forces IDLE immediately: `cs_n`=1 and `sclk`=1 asynchronously. The partial frame is discarded, `ADC_data` returns to 0, and the timer restarts at 0.

## Timing
- First tick occurs `SAMPLE_PERIOD` clocks after reset release.
- `cs_n` falls on the clock after the tick.
- The first `sclk` fall is `CLK_DIV` clocks after the `cs_n` fall. The first sampling rise is 2*`CLK_DIV` clocks after the `cs_n` fall.
- The 16th rise is 32*`CLK_DIV` clocks after the `cs_n` fall. `cs_n` rises one clock later. `sample_valid` and the new `ADC_data` appear in the clock after that.
- Tick-to-`sample_valid` latency is 32*`CLK_DIV`+3 clocks (131 at the defaults).
- `ADC_data` holds its value between strobes.

## Configuration
- `ADC_AVG4_EN` defined: DONE writes the 4-sample moving average instead of the raw sample.
  - A 4-deep history of raw samples is kept, reset to 0.
  - The 14-bit sum of the newest 4 raw samples is shifted right by 2 and truncated to 12 bits.
  - The first three outputs after reset include the zero history entries.
  - DONE timing is unchanged: the history and sum are registered so the average is ready in the DONE clock.
- Undefined: `ADC_data` is the raw sample. No history registers exist.

## Structure
- Shared package `scope_pkg`:
  - `ADC_WIDTH`=12
  - `SPI_FRAME_BITS`=16
  - the state enum `adc_state_t` (IDLE, CONV, DONE)
- Sub-module `spi_clk_div`: divider counter plus `sclk` toggle generation. Outputs `rise_pulse` and `fall_pulse` one-clock strobes.
- The FSM, shift register, tick timer and averaging stay in `adc_spi_sampler`.

## Test plan
- Raw frame: ADC model returns 0000_1010_1011_1100 with defaults -> `ADC_data`=12'hABC. `sample_valid` pulses once, 131 clocks after the tick. Exactly 16 `sclk` rises occur while `cs_n`=0.
- Extremes: frame data 12'hFFF and then 12'h000 -> `ADC_data` follows each value. Leading bits forced to 1 -> output is unaffected.
- Reset mid-CONV after 7 rises -> `cs_n`=1, `sclk`=1 and `ADC_data`=0 immediately, with no `sample_valid`. The next frame occurs `SAMPLE_PERIOD` clocks after release.
- Overrun: with `SAMPLE_PERIOD`=100 and `CLK_DIV`=4 (frame time 131 clocks) -> `overrun` is set and alternate ticks are dropped. Frames never overlap; `cs_n` is high at least one clock between frames.
- With `ADC_AVG4_EN`, samples 400, 800, 1200, 1600, 2000 -> outputs 100, 300, 600, 1000, 1400.
- With `CLK_DIV`=2 and sample 12'h123 -> the `sclk` period is 4 clocks and `ADC_data`=12'h123.
